scrambler_ctrl: RTL and testbench

Frame-synchronous controller for the RGB channel scrambler. It owns the 6-bit channel-routing control word: three 2-bit fields select the source for the output red, green and blue channels. The word is edited from single-cycle button pulses in manual mode, or stepped through a fixed preset table in auto mode. Edits are staged in a shadow register and committed to the live `control` output only on a frame boundary, so a frame never mixes two routings.

---
 rtl/scrambler_ctrl.sv | 113 +++++++++++
 tb/tb_scrambler_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/scrambler_ctrl.sv
// RGB channel-routing controller: manual field editing or auto preset stepping,
// with edits staged in a shadow word and committed only on frame_start.
module scrambler_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_auto,
  input  logic       frame_start,
  output logic [5:0] control,
  output logic [1:0] cursor,
  output logic       auto_mode,
  output logic       pending
);

  localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [5:0] IDENTITY = 6'b000110;

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t           state;
  logic [5:0]       shadow;
  logic [5:0]       shadow_nxt;
  logic [CNT_W-1:0] frame_cnt;
  logic [2:0]       preset_idx;
  logic [2:0]       preset_nxt_idx;
  logic             auto_first;

  function automatic logic [5:0] preset(input logic [2:0] idx);
    case (idx)
      3'd0:    preset = 6'b000110;
      3'd1:    preset = 6'b001001;
      3'd2:    preset = 6'b010010;
      3'd3:    preset = 6'b011000;
      3'd4:    preset = 6'b100001;
      3'd5:    preset = 6'b100100;
      3'd6:    preset = 6'b000000;
      default: preset = 6'b001111;
    endcase
  endfunction

  // Manual edit of the field under the (pre-move) cursor; 2-bit add wraps 11->00.
  always_comb begin
    shadow_nxt = shadow;
    if (btn_inc) begin
      case (cursor)
        2'd0:    shadow_nxt[5:4] = shadow[5:4] + 2'd1;
        2'd1:    shadow_nxt[3:2] = shadow[3:2] + 2'd1;
        2'd2:    shadow_nxt[1:0] = shadow[1:0] + 2'd1;
        default: shadow_nxt = shadow;
      endcase
    end
  end

  assign preset_nxt_idx = 3'(preset_idx + 3'd1);
  assign auto_mode      = (state == AUTO);
  // In AUTO the only pending word is the preset 0 waiting for its first commit.
  assign pending        = auto_mode ? auto_first : (shadow != control);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MANUAL;
      shadow     <= IDENTITY;
      control    <= IDENTITY;
      cursor     <= 2'd0;
      frame_cnt  <= '0;
      preset_idx <= 3'd0;
      auto_first <= 1'b0;
    end else begin
      case (state)
        MANUAL: begin
          if (btn_auto) begin
            state      <= AUTO;
            preset_idx <= 3'd0;
            frame_cnt  <= '0;
            shadow     <= preset(3'd0);
            cursor     <= 2'd0;
            auto_first <= 1'b1;
          end else begin
            shadow <= shadow_nxt;
            if (btn_sel) cursor <= (cursor == 2'd2) ? 2'd0 : 2'(cursor + 2'd1);
            if (frame_start) control <= shadow_nxt;
          end
        end
        AUTO: begin
          if (btn_auto) begin
            state      <= MANUAL;
            shadow     <= control;
            cursor     <= 2'd0;
            auto_first <= 1'b0;
          end else if (frame_start) begin
            if (auto_first) begin
              control    <= shadow;
              auto_first <= 1'b0;
            end else if (frame_cnt == CNT_LAST) begin
              frame_cnt  <= '0;
              preset_idx <= preset_nxt_idx;
              shadow     <= preset(preset_nxt_idx);
              control    <= preset(preset_nxt_idx);
            end else begin
              frame_cnt <= CNT_W'(frame_cnt + 1'b1);
            end
          end
        end
        default: state <= MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Self-checking bench for scrambler_ctrl: directed test-plan scenarios plus
// randomized pulses compared every cycle against a field-level behavioural model.
module tb_scrambler_ctrl;

  localparam int FPS = 2;

  logic       clk = 1'b0;
  logic       rst, btn_sel, btn_inc, btn_auto, frame_start;
  logic [5:0] control;
  logic [1:0] cursor;
  logic       auto_mode, pending;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  scrambler_ctrl #(.FRAMES_PER_STEP(FPS)) dut (
    .clk(clk), .rst(rst), .btn_sel(btn_sel), .btn_inc(btn_inc),
    .btn_auto(btn_auto), .frame_start(frame_start),
    .control(control), .cursor(cursor), .auto_mode(auto_mode), .pending(pending)
  );

  always #5 clk = ~clk;

  // Model state: fields indexed 0=red,1=green,2=blue.
  localparam logic [5:0] PRESETS [8] = '{6'b000110, 6'b001001, 6'b010010, 6'b011000,
                                         6'b100001, 6'b100100, 6'b000000, 6'b001111};
  logic [1:0] m_sh [3];
  logic [1:0] m_ct [3];
  int         m_cur, m_cnt, m_idx;
  bit         m_auto, m_first;

  task automatic load_fields(input logic [5:0] w, output logic [1:0] f [3]);
    f[0] = w[5:4]; f[1] = w[3:2]; f[2] = w[1:0];
  endtask

  function automatic logic [5:0] word_of(input logic [1:0] f [3]);
    return {f[0], f[1], f[2]};
  endfunction

  task automatic model_reset();
    load_fields(6'b000110, m_sh);
    load_fields(6'b000110, m_ct);
    m_cur = 0; m_cnt = 0; m_idx = 0; m_auto = 0; m_first = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (btn_auto) begin
      if (!m_auto) begin
        m_auto = 1; m_idx = 0; m_cnt = 0; m_first = 1; m_cur = 0;
        load_fields(PRESETS[0], m_sh);
      end else begin
        m_auto = 0; m_first = 0; m_cur = 0;
        m_sh = m_ct;
      end
    end else if (!m_auto) begin
      if (btn_inc) m_sh[m_cur] = m_sh[m_cur] + 2'd1;
      if (btn_sel) m_cur = (m_cur + 1) % 3;
      if (frame_start) m_ct = m_sh;
    end else if (frame_start) begin
      if (m_first) begin
        m_ct = m_sh; m_first = 0;
      end else if (m_cnt == FPS - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 8;
        load_fields(PRESETS[m_idx], m_sh);
        m_ct = m_sh;
      end else begin
        m_cnt++;
      end
    end
  endtask

  function automatic bit m_pending();
    return m_auto ? m_first : (word_of(m_sh) != word_of(m_ct));
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  initial model_reset();
  always @(posedge clk) model_step();

  // Continuous model comparison on the falling edge.
  always @(negedge clk) begin
    if (compare_en) begin
      check("model_control", control, word_of(m_ct));
      check("model_cursor", 6'(cursor), 6'(m_cur));
      check("model_auto", 6'(auto_mode), 6'(m_auto));
      check("model_pending", 6'(pending), 6'(m_pending()));
    end
  end

  task automatic cyc(input logic s, input logic i, input logic a, input logic f, input logic r);
    btn_sel = s; btn_inc = i; btn_auto = a; frame_start = f; rst = r;
    @(posedge clk);
    #1;
    btn_sel = 0; btn_inc = 0; btn_auto = 0; frame_start = 0; rst = 0;
  endtask

  initial begin
    btn_sel = 0; btn_inc = 0; btn_auto = 0; frame_start = 0; rst = 1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    compare_en = 1'b1;
    check("reset_control", control, 6'b000110);
    check("reset_cursor", 6'(cursor), 6'd0);
    check("reset_auto", 6'(auto_mode), 6'd0);
    check("reset_pending", 6'(pending), 6'd0);

    // Three increments of red: 00 -> 11, held until frame_start.
    repeat (3) cyc(0, 1, 0, 0, 0);
    check("inc3_pending", 6'(pending), 6'd1);
    check("inc3_control", control, 6'b000110);
    cyc(0, 0, 0, 1, 0);
    check("inc3_commit", control, 6'b110110);
    check("inc3_pending_clr", 6'(pending), 6'd0);

    // Increment uses pre-move cursor when inc and sel coincide.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("sel2_cursor", 6'(cursor), 6'd2);
    cyc(1, 1, 0, 0, 0);
    check("incsel_cursor", 6'(cursor), 6'd0);
    check("incsel_pending", 6'(pending), 6'd1);
    cyc(0, 1, 0, 1, 0);
    check("inc_commit", control, 6'b010111);

    // Auto stepping with FPS=2.
    cyc(0, 0, 1, 0, 0);
    check("auto_on", 6'(auto_mode), 6'd1);
    check("auto_pending", 6'(pending), 6'd1);
    check("auto_ctrl_hold", control, 6'b010111);
    for (int p = 1; p <= 23; p++) begin
      cyc(0, 0, 0, 1, 0);
      if (p == 1)  check("pulse1", control, 6'b000110);
      if (p == 2)  check("pulse2", control, 6'b000110);
      if (p == 3)  check("pulse3", control, 6'b001001);
      if (p == 5)  check("pulse5", control, 6'b010010);
      if (p == 7)  check("pulse7", control, 6'b011000);
      if (p == 15) check("pulse15", control, 6'b001111);
      if (p == 17) check("pulse17", control, 6'b000110);
      if (p == 23) check("pulse23", control, 6'b011000);
    end
    check("auto_pending_clr", 6'(pending), 6'd0);

    // Mode toggle beats frame_start.
    cyc(0, 0, 1, 1, 0);
    check("toggle_auto", 6'(auto_mode), 6'd0);
    check("toggle_control", control, 6'b011000);
    check("toggle_pending", 6'(pending), 6'd0);

    // Buttons ignored in AUTO.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("auto_ign_cursor", 6'(cursor), 6'd0);
    check("auto_ign_pending", 6'(pending), 6'd0);
    check("auto_ign_control", control, 6'b000110);

    // Reset beats a pending commit.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("pre_rst_pending", 6'(pending), 6'd1);
    cyc(0, 0, 0, 1, 1);
    check("rst_control", control, 6'b000110);
    check("rst_pending", 6'(pending), 6'd0);
    check("rst_cursor", 6'(cursor), 6'd0);

    // Randomized pulses against the model.
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 299) == 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
